// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit, 4-register multi-cycle processor:
// opcodes, ALU functions, controller states and datapath mux selects.
`timescale 1ns/1ps
package proc_pkg;

  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_BEQZ  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic PC_SRC_INC   = 1'b0;
  localparam logic PC_SRC_ALU   = 1'b1;
  localparam logic WB_SEL_ALU   = 1'b0;
  localparam logic WB_SEL_MEM   = 1'b1;
  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    HALT   = 4'd10
  } state_t;

endpackage

// File: rtl/ctrl_outdecode.sv
// Combinational strobe decode: Moore outputs of the controller state, with
// ir_we/pc_we/ready qualified by mem_ready or cond_zero, all forced low in reset.
`timescale 1ns/1ps
module ctrl_outdecode
  import proc_pkg::*;
(
  input  logic       i_rst,
  input  logic [3:0] i_state,
  input  logic [2:0] i_funct,
  input  logic       i_mem_ready,
  input  logic       i_cond_zero,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_addr_sel,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_pc_src,
  output logic       o_rf_we,
  output logic       o_wb_sel,
  output logic       o_alu_srcb,
  output logic       o_alu_srca,
  output logic [2:0] o_alu_op,
  output logic       o_ready
);

  state_t w_state;
  assign w_state = state_t'(i_state);

  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_addr_sel  = ADDR_SEL_PC;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_src    = PC_SRC_INC;
    o_rf_we     = 1'b0;
    o_wb_sel    = WB_SEL_ALU;
    o_alu_srcb  = 1'b0;
    o_alu_srca  = 1'b0;
    o_alu_op    = ALU_ADD;
    o_ready     = 1'b0;
    // Reset aborts whatever instruction is in flight, so nothing may commit.
    if (!i_rst) begin
      case (w_state)
        FETCH: begin
          o_mem_read = 1'b1;
          o_ir_we    = i_mem_ready;
          o_pc_we    = i_mem_ready;
        end
        EXEC_R: o_alu_op = i_funct;
        EXEC_I: o_alu_srcb = 1'b1;
        ADDR:   o_alu_srcb = 1'b1;
        MEM_RD: begin
          o_mem_read = 1'b1;
          o_addr_sel = ADDR_SEL_ALU;
        end
        MEM_WR: begin
          o_mem_write = 1'b1;
          o_addr_sel  = ADDR_SEL_ALU;
          o_ready     = i_mem_ready;
        end
        WB_ALU: begin
          o_rf_we = 1'b1;
          o_ready = 1'b1;
        end
        WB_MEM: begin
          o_rf_we  = 1'b1;
          o_wb_sel = WB_SEL_MEM;
          o_ready  = 1'b1;
        end
        // PC already holds PC+1 here, so PC + imm9 is the branch target.
        BRANCH: begin
          o_alu_srca = 1'b1;
          o_alu_srcb = 1'b1;
          o_pc_we    = i_cond_zero;
          o_pc_src   = PC_SRC_ALU;
          o_ready    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: state register, next-state sequencing through
// fetch/decode/execute/memory/writeback, and the sticky halted/illegal flags.
`timescale 1ns/1ps
module multicycle_ctrl
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [2:0] funct,
  input  logic       mem_ready,
  input  logic       cond_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       alu_srcb,
  output logic       alu_srca,
  output logic [2:0] alu_op,
  output logic       ready,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  logic   r_halted;
  logic   r_illegal;
  logic   w_set_halted;
  logic   w_set_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_halted)  r_halted  <= 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_halted  = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_ALU:            w_next = EXEC_R;
          OP_ADDI:           w_next = EXEC_I;
          OP_LOAD, OP_STORE: w_next = ADDR;
          OP_BEQZ:           w_next = BRANCH;
          OP_HALT: begin
            w_next       = HALT;
            w_set_halted = 1'b1;
          end
          default: begin
            w_next        = HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      EXEC_R, EXEC_I: w_next = WB_ALU;
      ADDR:   w_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD: if (mem_ready) w_next = WB_MEM;
      MEM_WR: if (mem_ready) w_next = FETCH;
      WB_ALU, WB_MEM, BRANCH: w_next = FETCH;
      HALT:   w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  // Flags read as clear from the first reset cycle, not one cycle later.
  assign halted  = r_halted & ~rst;
  assign illegal = r_illegal & ~rst;
  assign state   = r_state;

  ctrl_outdecode u_outdecode (
    .i_rst       (rst),
    .i_state     (r_state),
    .i_funct     (funct),
    .i_mem_ready (mem_ready),
    .i_cond_zero (cond_zero),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_addr_sel  (addr_sel),
    .o_ir_we     (ir_we),
    .o_pc_we     (pc_we),
    .o_pc_src    (pc_src),
    .o_rf_we     (rf_we),
    .o_wb_sel    (wb_sel),
    .o_alu_srcb  (alu_srcb),
    .o_alu_srca  (alu_srca),
    .o_alu_op    (alu_op),
    .o_ready     (ready)
  );

endmodule
